fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage. Keeps the PC, issues instruction-memory requests over a valid/ready port, and
//  presents {instruction_f, pc_f, mem_valid_f} to the decode-stage input register.
//  Honours stall_f and redirects (branch_d/branch_next_addr_d) from decode, discarding stale responses.
//  Keeps at most one request outstanding. With 1-cycle memory latency it sustains 1 instr/cycle.
// PARAMETERS
//  RESET_PC   32'h0000_0000  address of first fetch after reset; bits[1:0] must be 0
//  NOP_INSTR  32'h0000_0013  instruction_f value when mem_valid_f=0 (addi x0,x0,0)
// PORTS
//  clk                 in   1   clock, rising edge
//  rst_n               in   1   asynchronous reset, active low
//  stall_f             in   1   hazard unit: decode not accepting; hold presented instruction
//  branch_d            in   1   decode: redirect PC this cycle
//  branch_next_addr_d  in   32  decode: redirect target
//  imem_req_valid      out  1   request valid
//  imem_req_ready      in   1   memory accepts request (handshake = valid & ready)
//  imem_req_addr       out  32  request word address, bits[1:0]=0
//  imem_resp_valid     in   1   response valid, >=1 cycle after accepted request, in order
//  imem_resp_data      in   32  response instruction word
//  instruction_f       out  32  instruction presented to decode
//  pc_f                out  32  PC of instruction_f
//  mem_valid_f         out  1   instruction_f/pc_f valid
// BEHAVIOUR
//  State: pc_q (next fetch addr), pc_req (addr of outstanding req), kill, hold_instr/hold_pc,
//   FSM {S_BOOT, S_REQ, S_WAIT, S_HOLD}. Async reset: S_BOOT, pc_q=RESET_PC, kill=0, buffers=0.
//  Output reset values: imem_req_valid=0, imem_req_addr=RESET_PC, mem_valid_f=0,
//   instruction_f=NOP_INSTR, pc_f=0.
//  Redirect (redir = branch_d & ~stall_f; branch_d ignored while stall_f=1):
//   pc_q<=branch_next_addr_d & ~3. No request is issued in the redirect cycle.
//   mem_valid_f forced 0. Held buffer dropped. If a request is outstanding, kill<=1.
//  S_BOOT: no request. Next cycle -> S_REQ.
//  S_REQ: imem_req_valid=~redir, addr=pc_q. On handshake: pc_req<=pc_q, pc_q<=pc_q+4 -> S_WAIT.
//   On redir: stay S_REQ. A resp_valid seen in S_REQ is ignored.
//  S_WAIT: no resp -> stay; on redir set kill.
//   resp & kill: drop response, kill<=0 -> S_REQ. Second redirect while kill=1 only updates pc_q.
//   resp & ~kill & redir: drop response -> S_REQ.
//   resp & ~kill & stall_f: capture into hold buffer -> S_HOLD. mem_valid_f=1 this cycle.
//   resp & ~kill & ~stall_f: bypass resp to outputs (mem_valid_f=1, pc_f=pc_req); decode consumes it.
//    Same cycle imem_req_valid=1 @pc_q. Handshake -> stay S_WAIT (pc_req/pc_q advance), else -> S_REQ.
//  S_HOLD: outputs = hold buffer, mem_valid_f=1 (0 if redir).
//   ~stall_f & ~redir: consumed. Issue next req same cycle -> S_WAIT on handshake, else S_REQ.
//   redir -> S_REQ. stall_f -> stay; outputs stable.
//  Request issue only in S_REQ, in S_WAIT on an accepted response, or on S_HOLD release.
//   So at most one request is outstanding.
//  Once imem_req_valid=1 it is held with a stable address until ready, unless a redirect occurs.
//  pc arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
//  Redirect penalty: target request issued the cycle after branch_d.
//  Reset mid-operation: state cleared immediately, outputs return to reset values. Outstanding request is forgotten.
// STRUCTURE
//  Shared header riscv_defs.vh: NOP_INSTR and RESET_PC defaults, XLEN=32.
//  FSM state localparams stay local to this module.
//  Sub-module fetch_hold_buf: 1-entry {instr,pc} register with load/clear, async reset.
// TESTING
//  Reset release, ready=1, 1-cycle resp -> reqs 0x0,0x4,0x8 on consecutive cycles; mem_valid_f each cycle after first resp.
//  stall_f=1 for 3 cycles when resp @0x8 arrives -> pc_f=0x8 held stable, no new req until stall_f=0; then req 0xC.
//  branch_d=1, target 0x100, req 0x10 outstanding -> its resp dropped (mem_valid_f=0); next req addr 0x100.
//  Target 0x103 -> req addr 0x100. branch_d with stall_f=1 -> ignored, pc_q unchanged.
//  imem_req_ready=0 for 4 cycles -> imem_req_valid held 1, imem_req_addr constant, mem_valid_f=0.
//  Assert rst_n mid S_WAIT -> next req after release at RESET_PC; late resp ignored; pc_q 0xFFFFFFFC wraps to 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and address helpers.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // Instruction fetches are word aligned; low two address bits are forced to zero.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel plus in-order response channel.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} buffer that parks a response while decode is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // Clear wins over load so a redirect always discards the parked instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction-memory request at a time and
// presents the returned instruction to decode, honouring stalls and redirects.
//
//  state  | meaning
//  S_BOOT | first cycle out of reset, no request
//  S_REQ  | request for pc_q offered, waiting for ready
//  S_WAIT | one request outstanding, waiting for its response
//  S_HOLD | response parked in hold buffer while decode stalls
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall_f,
  input  logic            i_branch_d,
  input  logic [XLEN-1:0] i_branch_next_addr_d,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] o_instruction_f,
  output logic [XLEN-1:0] o_pc_f,
  output logic            o_mem_valid_f
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_pc_q;
  logic [XLEN-1:0] r_pc_req;
  logic            r_kill;

  logic            w_redir;
  logic            w_req_valid;
  logic            w_hs;
  logic            w_load_hold;
  logic            w_clr_hold;
  logic            w_set_kill;
  logic            w_clr_kill;
  logic [XLEN-1:0] w_hold_instr;
  logic [XLEN-1:0] w_hold_pc;

  // A branch from decode is only honoured when decode is actually advancing.
  assign w_redir = i_branch_d & ~i_stall_f;
  assign w_hs    = w_req_valid & imem.imem_req_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_next_state;
  end

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT: w_next_state = S_REQ;
      S_REQ:  w_next_state = w_hs ? S_WAIT : S_REQ;
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          if (r_kill || w_redir) w_next_state = S_REQ;
          else if (i_stall_f)    w_next_state = S_HOLD;
          else                   w_next_state = w_hs ? S_WAIT : S_REQ;
        end
      end
      S_HOLD: begin
        if (w_redir)        w_next_state = S_REQ;
        else if (i_stall_f) w_next_state = S_HOLD;
        else                w_next_state = w_hs ? S_WAIT : S_REQ;
      end
      default: w_next_state = S_BOOT;
    endcase
  end

  // Outputs and datapath controls; responses are bypassed straight to decode when it is free.
  always_comb begin
    w_req_valid     = 1'b0;
    w_load_hold     = 1'b0;
    w_clr_hold      = w_redir;
    w_set_kill      = 1'b0;
    w_clr_kill      = 1'b0;
    o_mem_valid_f   = 1'b0;
    o_instruction_f = NOP_INSTR;
    o_pc_f          = '0;
    case (r_state)
      S_REQ: w_req_valid = ~w_redir;
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          if (r_kill) begin
            w_clr_kill = 1'b1;
          end else if (!w_redir) begin
            o_mem_valid_f   = 1'b1;
            o_instruction_f = imem.imem_resp_data;
            o_pc_f          = r_pc_req;
            if (i_stall_f) w_load_hold = 1'b1;
            else           w_req_valid = 1'b1;
          end
        end else if (w_redir) begin
          w_set_kill = 1'b1;
        end
      end
      S_HOLD: begin
        if (!w_redir) begin
          o_mem_valid_f   = 1'b1;
          o_instruction_f = w_hold_instr;
          o_pc_f          = w_hold_pc;
          if (!i_stall_f) begin
            w_req_valid = 1'b1;
            w_clr_hold  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // PC bookkeeping: redirect target, or advance on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_q   <= RESET_PC;
      r_pc_req <= '0;
    end else if (w_redir) begin
      r_pc_q <= word_align(i_branch_next_addr_d);
    end else if (w_hs) begin
      r_pc_req <= r_pc_q;
      r_pc_q   <= r_pc_q + 32'd4;
    end
  end

  // Kill marks the outstanding response as stale after a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_kill <= 1'b0;
    else if (w_clr_kill) r_kill <= 1'b0;
    else if (w_set_kill) r_kill <= 1'b1;
  end

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load_hold),
    .i_clear (w_clr_hold),
    .i_instr (imem.imem_resp_data),
    .i_pc    (r_pc_req),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc)
  );

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_pc_q;

endmodule
